// File: rtl/rtc_uart_cmd.sv
// rtc_uart_cmd: parses 0x55-framed UART commands into PCF8563 controller requests and streams back framed responses.
// Define RTC_CMD_CHECKSUM_EN to add a trailing XOR checksum byte to every frame and every response.
module rtc_uart_cmd #(
    parameter logic [23:0] BYTE_TIMEOUT = 24'd5_000_000,
    parameter logic [23:0] DONE_TIMEOUT = 24'd10_000_000,
    parameter logic [15:0] STARTUP_HOLD = 16'd50_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        set_time,
    output logic [23:0] time_2_set,
    output logic        set_date,
    output logic [31:0] date_2_set,
    output logic        read,
    input  logic [23:0] time_read,
    input  logic [31:0] date_read,
    input  logic        set_done,
    input  logic        read_done
);
    typedef enum logic [2:0] {S_INIT, S_HDR, S_OP, S_PAY, S_ISSUE, S_WAIT, S_GAP, S_TX} state_t;

`ifdef RTC_CMD_CHECKSUM_EN
    localparam logic [2:0] CHK_LEN = 3'd1;
`else
    localparam logic [2:0] CHK_LEN = 3'd0;
`endif

    state_t      state, state_nxt;
    logic [23:0] tmr, tmr_inc;
    logic [1:0]  op_q;
    logic [2:0]  cnt;
    logic [31:0] sr, pay_nxt;
    logic [55:0] rd_buf, rd_sh;
    logic [7:0]  rsp_code, tx_byte;
    logic [3:0]  idx, last_idx;
    logic        tx_hold, tx_go, is_pay, chk_ok, done_match, byte_to, done_to, in_rx;

`ifdef RTC_CMD_CHECKSUM_EN
    logic [7:0] chk, tx_x;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            chk  <= 8'h00;
            tx_x <= 8'h00;
        end else begin
            if (state == S_OP && rx_valid)
                chk <= rx_data;
            else if (state == S_PAY && rx_valid)
                chk <= chk ^ rx_data;
            if (state == S_GAP)
                tx_x <= 8'h00;
            else if (tx_go && idx != 4'd0)
                tx_x <= tx_x ^ tx_byte;
        end
    end

    // The last byte of a checked frame is the checksum, not payload.
    assign chk_ok = (chk ^ rx_data) == 8'h00;
    assign is_pay = cnt != 3'd1;
`else
    assign chk_ok = 1'b1;
    assign is_pay = 1'b1;
`endif

    assign tmr_inc    = tmr + 24'd1;
    assign in_rx      = (state == S_OP) || (state == S_PAY);
    assign byte_to    = in_rx && (tmr_inc >= BYTE_TIMEOUT);
    assign done_to    = (state == S_WAIT) && (tmr_inc >= DONE_TIMEOUT);
    assign done_match = (op_q == 2'd3) ? read_done : set_done;
    assign pay_nxt    = is_pay ? {sr[23:0], rx_data} : sr;
    assign last_idx   = ((rsp_code == 8'h03) ? 4'd8 : 4'd1) + {1'b0, CHK_LEN};

    always_comb begin
        rd_sh   = rd_buf << {idx - 4'd2, 3'b000};
        tx_byte = rd_sh[55:48];
        if (idx == 4'd0)
            tx_byte = 8'hAA;
        else if (idx == 4'd1)
            tx_byte = rsp_code;
`ifdef RTC_CMD_CHECKSUM_EN
        if (idx == last_idx)
            tx_byte = tx_x;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (tmr_inc >= {8'd0, STARTUP_HOLD}) state_nxt = S_HDR;
            S_HDR:   if (rx_valid && rx_data == 8'h55) state_nxt = S_OP;
            S_OP: begin
                if (rx_valid) begin
                    if (rx_data == 8'h01 || rx_data == 8'h02)
                        state_nxt = S_PAY;
                    else if (rx_data == 8'h03)
                        state_nxt = (CHK_LEN != 3'd0) ? S_PAY : S_ISSUE;
                    else
                        state_nxt = S_GAP;
                end else if (byte_to) begin
                    state_nxt = S_HDR;
                end
            end
            S_PAY: begin
                if (rx_valid) begin
                    if (cnt == 3'd1)
                        state_nxt = chk_ok ? S_ISSUE : S_GAP;
                end else if (byte_to) begin
                    state_nxt = S_HDR;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_match || done_to) state_nxt = S_GAP;
            S_GAP:   state_nxt = S_TX;
            S_TX:    if (tx_go && idx == last_idx) state_nxt = S_HDR;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        set_time = 1'b0;
        set_date = 1'b0;
        read     = 1'b0;
        tx_go    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        if (state == S_ISSUE) begin
            set_time = op_q == 2'd1;
            set_date = op_q == 2'd2;
            read     = op_q == 2'd3;
        end
        if (state == S_TX) begin
            tx_go    = !tx_hold && !tx_busy;
            tx_start = tx_go;
            tx_data  = tx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmr        <= 24'd0;
            op_q       <= 2'd0;
            cnt        <= 3'd0;
            sr         <= 32'd0;
            time_2_set <= 24'd0;
            date_2_set <= 32'd0;
            rd_buf     <= 56'd0;
            rsp_code   <= 8'h00;
            idx        <= 4'd0;
            tx_hold    <= 1'b0;
        end else begin
            // One timer serves startup hold, byte timeout and done timeout.
            tmr <= (state_nxt != state || (in_rx && rx_valid)) ? 24'd0 : tmr_inc;
            case (state)
                S_OP: if (rx_valid) begin
                    op_q <= rx_data[1:0];
                    cnt  <= ((rx_data == 8'h02) ? 3'd4 : (rx_data == 8'h01) ? 3'd3 : 3'd0) + CHK_LEN;
                    sr   <= 32'd0;
                    if (rx_data == 8'h00 || rx_data > 8'h03)
                        rsp_code <= 8'hEE;
                end
                S_PAY: if (rx_valid) begin
                    cnt <= cnt - 3'd1;
                    sr  <= pay_nxt;
                    if (cnt == 3'd1) begin
                        if (!chk_ok)
                            rsp_code <= 8'hEC;
                        else if (op_q == 2'd1)
                            time_2_set <= pay_nxt[23:0];
                        else if (op_q == 2'd2)
                            date_2_set <= pay_nxt;
                    end
                end
                S_WAIT: begin
                    if (done_match) begin
                        rsp_code <= {6'd0, op_q};
                        if (op_q == 2'd3)
                            rd_buf <= {date_read, time_read};
                    end else if (done_to) begin
                        rsp_code <= 8'hE0;
                    end
                end
                S_GAP: begin
                    idx     <= 4'd0;
                    tx_hold <= 1'b0;
                end
                S_TX: begin
                    tx_hold <= tx_go;
                    if (tx_go)
                        idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/rtc_uart_cmd.md
Name: rtc_uart_cmd

Overview:
- Host-command front end that sits directly upstream of the PCF8563 RTC controller.
- Parses framed hex command bytes from the UART receiver into set-time, set-date and read requests for the controller.
- Waits for the controller's done strobes, then streams a framed response back through the UART transmitter.
- All data is passed through as raw BCD bytes. No BCD conversion happens here.

Parameters:
- BYTE_TIMEOUT, 24'd5_000_000: maximum idle cycles between bytes of one frame. On expiry the parser returns to the header state.
- DONE_TIMEOUT, 24'd10_000_000: maximum cycles to wait for set_done or read_done after a request is issued.
- STARTUP_HOLD, 16'd50_000: cycles after reset before any request may be issued. This covers the controller's init write.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle strobe to start transmitting tx_data.
- tx_busy  in  1  transmitter busy.
- set_time  out  1  one-cycle request pulse to the controller.
- time_2_set  out  24  {hour, min, sec}.
- set_date  out  1  one-cycle request pulse.
- date_2_set  out  32  {year, month, day, weekday}.
- read  out  1  one-cycle request pulse.
- time_read  in  24  {hour, min, sec}.
- date_read  in  32  {year, month, day, weekday}.
- set_done  in  1  controller write-complete strobe.
- read_done  in  1  controller read-complete strobe.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
- Reset values: all outputs 0, state S_INIT, startup counter 0.
- Frame format (host to block): 0x55, opcode, payload.
  - 0x01 set time: 3 payload bytes in order hour, min, sec.
  - 0x02 set date: 4 payload bytes in order year, month, day, weekday.
  - 0x03 read: no payload.
- Payload packing: bytes shift into the target register MSB-first, so the first byte lands in bits [23:16] of time_2_set or [31:24] of date_2_set.
- States:
  - S_INIT counts STARTUP_HOLD cycles, then goes to S_HDR.
  - S_HDR: a non-0x55 byte is dropped. 0x55 goes to S_OP.
  - S_OP:
    - Opcode 1 or 2 goes to S_PAY with the payload byte count loaded.
    - Opcode 3 goes to S_ISSUE.
    - Any other opcode queues error response 0xAA 0xEE.
  - S_PAY collects the payload bytes, then goes to S_ISSUE.
  - S_ISSUE asserts exactly one of set_time, set_date or read for one cycle. time_2_set and date_2_set are stable from that cycle until the next issue. Then goes to S_WAIT.
  - S_WAIT:
    - The matching done strobe (set_done for ops 1/2, read_done for op 3) captures time_read/date_read for op 3 and goes to S_GAP.
    - A non-matching done strobe is ignored.
  - S_GAP holds one idle cycle, then goes to S_TX.
  - S_TX sends the response bytes.
- Responses:
  - Op 1/2: 0xAA, op.
  - Op 3: 0xAA, 0x03, year, month, day, weekday, hour, min, sec (9 bytes).
  - DONE_TIMEOUT expiry in S_WAIT: 0xAA 0xE0.
- Tx handshake:
  - tx_start pulses one cycle only when tx_busy=0.
  - After each pulse the block ignores tx_busy for one cycle, then waits for tx_busy=0 before the next byte.
  - After the last byte it returns to S_HDR.
- Byte timeout: the counter resets on every rx_valid. It is active in S_OP and S_PAY only. Expiry returns to S_HDR silently, with no request and no response.
- rx_valid outside S_HDR, S_OP and S_PAY is dropped. There is no buffering, so the host must wait for the response.
- rx_valid in the same cycle as a timeout expiry: the byte wins and the counter resets.
- Reset asserted mid-frame or mid-response aborts immediately to the reset state. STARTUP_HOLD is re-applied.

Optional Feature:
- RTC_CMD_CHECKSUM_EN defined:
  - Every frame carries one extra trailing byte equal to the XOR of opcode and all payload bytes.
  - On mismatch, no request is issued and the response is 0xAA 0xEC.
  - Every response also gets a trailing XOR byte covering all bytes after 0xAA.
- RTC_CMD_CHECKSUM_EN undefined: no checksum byte in either direction, and the checksum logic is absent.

Test Plan:
- Rx 55 01 12 34 56; set_done pulsed 100 cycles after set_time -> one set_time pulse with time_2_set=0x123456; tx sequence AA 01.
- Rx 55 02 24 06 15 03; set_done pulsed -> one set_date pulse with date_2_set=0x24061503; tx sequence AA 02.
- Rx 55 03; read_done pulsed with date_read=0x25123104 and time_read=0x235958 -> one read pulse; tx sequence AA 03 25 12 31 04 23 59 58 (9 bytes). tx_start is never asserted while tx_busy=1.
- Rx 55 07 -> tx sequence AA EE and no request pulse. Rx 55 01 12, then BYTE_TIMEOUT idle -> no output. A following 55 03 is processed normally.
- Rx 55 03 with no read_done -> after DONE_TIMEOUT, tx sequence AA E0. Then rstn low for one cycle mid-frame -> all outputs 0 and no request before STARTUP_HOLD elapses.
- With RTC_CMD_CHECKSUM_EN: rx 55 01 12 34 56 71 -> set_time pulse; tx sequence AA 01 01. Rx 55 01 12 34 56 00 -> no pulse; tx sequence AA EC EC.
